pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the single-cycle CPU.
- Consumer end of the next-PC path: holds the architectural PC and issues word fetches to instruction memory over a valid/ready request channel. Presents each fetched instruction to decode and exports pc/pc_plus4 to the next-PC logic.
- On retirement (inst_valid & inst_ready), loads next_pc_in and starts the next fetch.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_fetch_unit_pc_reg.sv | 21 ++
 rtl/pc_fetch_unit.sv | 94 +++++++++
 tb/tb_pc_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, reset PC default and NOP encoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10,
        S_HALT = 2'b11
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Architectural program-counter register: synchronous reset to RESET_PC, load-enabled update.
module pc_reg #(
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: issues word fetches, holds the fetched
// instruction for decode, and advances the PC on retirement.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] next_pc_in,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_resp_valid,
    input  logic [31:0]   imem_resp_data,
    output logic [31:0]   inst,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic          pc_misalign
);

    fetch_state_t state;
    logic         drop;
    logic         retire;
    logic         next_aligned;
    logic         pc_load;

    assign retire       = (state == S_HOLD) && inst_ready;
    assign next_aligned = (next_pc_in[1:0] == 2'b00);
    assign pc_load      = retire && next_aligned;

    pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (next_pc_in),
        .q    (pc)
    );

    assign pc_plus4       = pc + AW'(4);
    assign imem_addr      = pc;
    // Gated by rst so no request is offered while reset is asserted.
    assign imem_req_valid = (state == S_REQ) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            inst        <= NOP_INST;
            inst_valid  <= 1'b0;
            pc_misalign <= 1'b0;
            // A request still outstanding at reset will answer later; swallow that one response.
            drop        <= ((state == S_WAIT) && !imem_resp_valid) || (drop && !imem_resp_valid);
        end else begin
            if (drop && imem_resp_valid) begin
                drop <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid && !drop) begin
                        inst       <= imem_resp_data;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        if (next_aligned) begin
                            state <= S_REQ;
                        end else begin
                            pc_misalign <= 1'b1;
                            state       <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed cycle-table bench for pc_fetch_unit plus a hand-written long-latency fetch.
module tb_pc_fetch_unit;

    localparam logic [31:0] A1    = 32'h0010_0093;
    localparam logic [31:0] A2    = 32'h0020_0113;
    localparam logic [31:0] A3    = 32'h0030_0193;
    localparam logic [31:0] A4    = 32'h0040_0213;
    localparam logic [31:0] LW    = 32'h8C22_0004;
    localparam logic [31:0] A5    = 32'h0050_0293;
    localparam logic [31:0] A6    = 32'h0060_0313;
    localparam logic [31:0] A7    = 32'h0070_0393;
    localparam logic [31:0] A8    = 32'h0080_0413;
    localparam logic [31:0] STALE = 32'hBADB_AD00;
    localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc_in;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        pc_misalign;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .next_pc_in      (next_pc_in),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .pc_misalign     (pc_misalign)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ir;
        logic [31:0] npc;
        logic        chk;
        logic [31:0] pc;
        logic        rq;
        logic        iv;
        logic [31:0] inst;
        logic        mis;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(logic r, logic rdy, logic rv, logic [31:0] rdata, logic ir,
                                logic [31:0] npc, logic chk, logic [31:0] epc, logic rq,
                                logic iv, logic [31:0] einst, logic mis);
        row_t x;
        x.rst = r; x.rdy = rdy; x.rv = rv; x.rdata = rdata; x.ir = ir; x.npc = npc;
        x.chk = chk; x.pc = epc; x.rq = rq; x.iv = iv; x.inst = einst; x.mis = mis;
        return x;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input row_t x);
        rst = x.rst; imem_req_ready = x.rdy; imem_resp_valid = x.rv;
        imem_resp_data = x.rdata; inst_ready = x.ir; next_pc_in = x.npc;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; inst_ready = 1'b0; next_pc_in = '0;

        // Reset, then always-ready 1-cycle memory.
        rows.push_back(mk(1,0,0,0,    0,0,            0, 0,0,0,0,0));
        rows.push_back(mk(1,0,0,0,    0,0,            1, 0,0,0,0,0));
        rows.push_back(mk(0,1,0,0,    0,0,            1, 0,1,0,0,0));
        rows.push_back(mk(0,1,1,A1,   0,0,            1, 0,0,0,0,0));
        rows.push_back(mk(0,1,0,0,    1,32'h4,        1, 0,0,1,A1,0));
        rows.push_back(mk(0,1,0,0,    0,0,            1, 32'h4,1,0,A1,0));
        rows.push_back(mk(0,1,1,A2,   0,0,            1, 32'h4,0,0,A1,0));
        rows.push_back(mk(0,1,0,0,    1,32'h8,        1, 32'h4,0,1,A2,0));
        rows.push_back(mk(0,1,0,0,    0,0,            1, 32'h8,1,0,A2,0));
        rows.push_back(mk(0,1,1,A3,   0,0,            1, 32'h8,0,0,A2,0));
        rows.push_back(mk(0,1,0,0,    1,32'h10,       1, 32'h8,0,1,A3,0));
        // Request stalled 5 cycles at 0x10.
        for (int i = 0; i < 5; i++)
            rows.push_back(mk(0,0,0,0, 0,0,           1, 32'h10,1,0,A3,0));
        rows.push_back(mk(0,1,0,0,    0,0,            1, 32'h10,1,0,A3,0));
        rows.push_back(mk(0,0,0,0,    0,0,            1, 32'h10,0,0,A3,0));
        rows.push_back(mk(0,0,1,A4,   0,0,            1, 32'h10,0,0,A3,0));
        rows.push_back(mk(0,0,0,0,    1,32'h20,       1, 32'h10,0,1,A4,0));
        // inst_ready outside S_HOLD is ignored; hold LW for 4 cycles then retire.
        rows.push_back(mk(0,1,0,0,    1,32'h46,       1, 32'h20,1,0,A4,0));
        rows.push_back(mk(0,1,1,LW,   1,32'h46,       1, 32'h20,0,0,A4,0));
        rows.push_back(mk(0,1,1,JUNK, 0,0,            1, 32'h20,0,1,LW,0));
        for (int i = 0; i < 3; i++)
            rows.push_back(mk(0,1,0,0, 0,0,           1, 32'h20,0,1,LW,0));
        rows.push_back(mk(0,1,0,0,    1,32'h40,       1, 32'h20,0,1,LW,0));
        rows.push_back(mk(0,1,0,0,    0,0,            1, 32'h40,1,0,LW,0));
        // Misaligned retire halts.
        rows.push_back(mk(0,1,1,A5,   0,0,            1, 32'h40,0,0,LW,0));
        rows.push_back(mk(0,1,0,0,    1,32'h46,       1, 32'h40,0,1,A5,0));
        for (int i = 0; i < 3; i++)
            rows.push_back(mk(0,1,1,JUNK, 1,32'h8,    1, 32'h40,0,0,A5,1));
        rows.push_back(mk(1,0,0,0,    0,0,            1, 32'h40,0,0,A5,1));
        rows.push_back(mk(0,1,0,0,    0,0,            1, 0,1,0,0,0));
        // Reset in S_WAIT; stale response two cycles later is dropped.
        rows.push_back(mk(1,0,0,0,    0,0,            1, 0,0,0,0,0));
        rows.push_back(mk(0,1,0,0,    0,0,            1, 0,1,0,0,0));
        rows.push_back(mk(0,0,1,STALE,0,0,            1, 0,0,0,0,0));
        rows.push_back(mk(0,0,0,0,    0,0,            1, 0,0,0,0,0));
        rows.push_back(mk(0,0,1,A6,   0,0,            1, 0,0,0,0,0));
        rows.push_back(mk(0,0,0,0,    1,32'hFFFF_FFFC,1, 0,0,1,A6,0));
        // PC wrap through pc_plus4.
        rows.push_back(mk(0,1,0,0,    0,0,            1, 32'hFFFF_FFFC,1,0,A6,0));
        rows.push_back(mk(0,1,1,A7,   0,0,            1, 32'hFFFF_FFFC,0,0,A6,0));
        rows.push_back(mk(0,0,0,0,    1,32'h0,        1, 32'hFFFF_FFFC,0,1,A7,0));
        rows.push_back(mk(0,0,0,0,    0,0,            1, 0,1,0,A7,0));

        foreach (rows[i]) begin
            @(negedge clk);
            drive(rows[i]);
            #1;
            if (rows[i].chk) begin
                cmp("pc",             i, pc,                     rows[i].pc);
                cmp("pc_plus4",       i, pc_plus4,               rows[i].pc + 32'd4);
                cmp("imem_addr",      i, imem_addr,              rows[i].pc);
                cmp("imem_req_valid", i, {31'b0, imem_req_valid}, {31'b0, rows[i].rq});
                cmp("inst_valid",     i, {31'b0, inst_valid},     {31'b0, rows[i].iv});
                cmp("inst",           i, inst,                   rows[i].inst);
                cmp("pc_misalign",    i, {31'b0, pc_misalign},    {31'b0, rows[i].mis});
            end
        end

        // Wrap boundary stated directly.
        cmp("wrap_pc_plus4", 0, (rows[rows.size()-2].pc + 32'd4), 32'h0);

        // Long-latency fetch at 0x0: response three cycles after acceptance.
        @(negedge clk);
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; inst_ready = 1'b0;
        #1 cmp("lat3_req_valid", 0, {31'b0, imem_req_valid}, 32'd1);
        @(negedge clk);
        imem_req_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        imem_resp_valid = 1'b1; imem_resp_data = A8;
        @(negedge clk);
        imem_resp_valid = 1'b0; imem_resp_data = JUNK;
        begin
            int budget;
            budget = 8;
            while (!inst_valid && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            cmp("lat3_inst_valid", budget, {31'b0, inst_valid}, 32'd1);
        end
        #1;
        cmp("lat3_inst", 0, inst, A8);
        cmp("lat3_pc",   0, pc,   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
